// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator.
// A prescaler produces a registered pixel tick every CLK_DIV clocks; every
// output is registered from that tick, so new pixel data appears in the clock
// after a tick, flagged by a one-clock valid_o strobe. Run/stop control lets
// the current frame finish before the generator goes idle.
// Optional feature: define VTG_RASTER_IRQ_EN to add raster_line_i/raster_irq_o.
module video_timing_gen #(
    parameter int  CLK_DIV     = 2,
    parameter int  H_VISIBLE   = 640,
    parameter int  H_FP        = 16,
    parameter int  H_SYNC      = 96,
    parameter int  H_BP        = 48,
    parameter int  V_VISIBLE   = 480,
    parameter int  V_FP        = 10,
    parameter int  V_SYNC      = 2,
    parameter int  V_BP        = 33,
    parameter bit  HSYNC_POL   = 1'b0,
    parameter bit  VSYNC_POL   = 1'b0,
    parameter int  FRAME_CNT_W = 16,
    localparam int H_TOTAL     = H_VISIBLE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL     = V_VISIBLE + V_FP + V_SYNC + V_BP,
    localparam int X_W         = $clog2(H_TOTAL),
    localparam int Y_W         = $clog2(V_TOTAL)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   blank_n_o,
    output logic [X_W-1:0]         x_o,
    output logic [Y_W-1:0]         y_o,
    output logic                   valid_o,
    output logic                   end_of_line_o,
    output logic                   end_of_visible_line_o,
    output logic                   end_of_frame_o,
    output logic                   next_line_visible_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o,
    output logic                   running_o
`ifdef VTG_RASTER_IRQ_EN
    ,
    input  logic [Y_W-1:0]         raster_line_i,
    output logic                   raster_irq_o
`endif
);

    if (CLK_DIV < 1 || H_VISIBLE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_VISIBLE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
        $error("video_timing_gen: CLK_DIV and every timing field must be > 0");
    end

    localparam int P_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [P_W-1:0] P_LAST     = P_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0] X_LAST     = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] X_VIS      = X_W'(H_VISIBLE);
    localparam logic [X_W-1:0] HS_BEG     = X_W'(H_VISIBLE + H_FP);
    localparam logic [X_W-1:0] HS_END     = X_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] Y_LAST     = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_VIS      = Y_W'(V_VISIBLE);
    localparam logic [Y_W-1:0] Y_VIS_LAST = Y_W'(V_VISIBLE - 1);
    localparam logic [Y_W-1:0] VS_BEG     = Y_W'(V_VISIBLE + V_FP);
    localparam logic [Y_W-1:0] VS_END     = Y_W'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic HS_ON  = HSYNC_POL;
    localparam logic HS_OFF = ~HSYNC_POL;
    localparam logic VS_ON  = VSYNC_POL;
    localparam logic VS_OFF = ~VSYNC_POL;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP_PEND} state_e;

    state_e                 state_q, state_d;
    logic [P_W-1:0]         prescaler_q, prescaler_d;
    logic                   tick_q, tick_d;
    logic [X_W-1:0]         x_q, x_d;
    logic [Y_W-1:0]         y_q, y_d;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   blank_n_q, blank_n_d;
    logic                   valid_q, valid_d;
    logic                   eol_q, eol_d;
    logic                   evl_q, evl_d;
    logic                   eof_q, eof_d;
    logic                   nlv_q, nlv_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
`ifdef VTG_RASTER_IRQ_EN
    logic                   raster_irq_q, raster_irq_d;
`endif

    // Per-beat scratch: whether this tick presents a pixel, and which one.
    logic                   present;
    logic                   advance;
    logic [X_W-1:0]         nx;
    logic [Y_W-1:0]         ny;

    // Prescaler, run/stop state machine, raster position and decoded outputs.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        prescaler_d = (prescaler_q == '0) ? P_LAST : prescaler_q - P_W'(1);
        tick_d      = (prescaler_q == '0);
        x_d         = x_q;
        y_d         = y_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        blank_n_d   = blank_n_q;
        valid_d     = 1'b0;
        eol_d       = 1'b0;
        evl_d       = 1'b0;
        eof_d       = 1'b0;
        nlv_d       = nlv_q;
        frame_cnt_d = frame_cnt_q;
        present     = 1'b0;
        advance     = 1'b0;
        nx          = x_q;
        ny          = y_q;
`ifdef VTG_RASTER_IRQ_EN
        raster_irq_d = 1'b0;
`endif

        if (tick_q) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_d = ST_RUN;
                        present = 1'b1;
                        nx      = '0;
                        ny      = '0;
                    end
                end
                ST_RUN: begin
                    advance = 1'b1;
                    if (!enable_i) state_d = ST_STOP_PEND;
                end
                ST_STOP_PEND: begin
                    if (enable_i) begin
                        state_d = ST_RUN;
                        advance = 1'b1;
                    end else if (x_q == X_LAST && y_q == Y_LAST) begin
                        // Frame finished: park with syncs inactive and blanking on.
                        state_d   = ST_IDLE;
                        hsync_d   = HS_OFF;
                        vsync_d   = VS_OFF;
                        blank_n_d = 1'b0;
                    end else begin
                        advance = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (advance) begin
            present = 1'b1;
            if (x_q == X_LAST) begin
                nx = '0;
                if (y_q == Y_LAST) begin
                    ny          = '0;
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                end else begin
                    ny = y_q + Y_W'(1);
                end
            end else begin
                nx = x_q + X_W'(1);
            end
        end

        if (present) begin
            valid_d   = 1'b1;
            x_d       = nx;
            y_d       = ny;
            hsync_d   = (nx >= HS_BEG && nx < HS_END) ? HS_ON : HS_OFF;
            // vsync depends on y only, and y only moves on x wrap, so its edges land at x==0.
            vsync_d   = (ny >= VS_BEG && ny < VS_END) ? VS_ON : VS_OFF;
            blank_n_d = (nx < X_VIS) && (ny < Y_VIS);
            eol_d     = (nx == X_VIS);
            evl_d     = (nx == X_VIS) && (ny < Y_VIS);
            eof_d     = (nx == X_VIS) && (ny == Y_VIS_LAST);
            // Line after the last one is line 0, which is always visible.
            nlv_d     = (ny == Y_LAST) ? 1'b1 : (ny < Y_VIS_LAST);
`ifdef VTG_RASTER_IRQ_EN
            raster_irq_d = (nx == X_VIS) && (ny == raster_line_i);
`endif
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            prescaler_q <= '0;
            tick_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            hsync_q     <= HS_OFF;
            vsync_q     <= VS_OFF;
            blank_n_q   <= 1'b0;
            valid_q     <= 1'b0;
            eol_q       <= 1'b0;
            evl_q       <= 1'b0;
            eof_q       <= 1'b0;
            nlv_q       <= 1'b1;
            frame_cnt_q <= '0;
`ifdef VTG_RASTER_IRQ_EN
            raster_irq_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            tick_q      <= tick_d;
            x_q         <= x_d;
            y_q         <= y_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            blank_n_q   <= blank_n_d;
            valid_q     <= valid_d;
            eol_q       <= eol_d;
            evl_q       <= evl_d;
            eof_q       <= eof_d;
            nlv_q       <= nlv_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef VTG_RASTER_IRQ_EN
            raster_irq_q <= raster_irq_d;
`endif
        end
    end

    assign hsync_o               = hsync_q;
    assign vsync_o               = vsync_q;
    assign blank_n_o             = blank_n_q;
    assign x_o                   = x_q;
    assign y_o                   = y_q;
    assign valid_o               = valid_q;
    assign end_of_line_o         = eol_q;
    assign end_of_visible_line_o = evl_q;
    assign end_of_frame_o        = eof_q;
    assign next_line_visible_o   = nlv_q;
    assign frame_cnt_o           = frame_cnt_q;
    assign running_o             = (state_q != ST_IDLE);
`ifdef VTG_RASTER_IRQ_EN
    assign raster_irq_o          = raster_irq_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen on a small 14x8 raster with CLK_DIV=2.
// A behavioural model (pixel ticks every CLK_DIV clocks, position arithmetic,
// frame-boundary stop rule) is compared with the DUT every clock, alongside a
// start-up vector table and hand-written sequences for multi-cycle corners.
module tb_video_timing_gen;

    localparam int CLK_DIV = 2;
    localparam int HV = 8, HF = 2, HS = 2, HB = 2;
    localparam int VV = 4, VF = 1, VS = 1, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int XW = 4, YW = 3, FW = 16;
    localparam bit HPOL = 1'b0, VPOL = 1'b0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          hsync, vsync, blank_n, valid, eol, evl, eof, nlv, running;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [FW-1:0] fc;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic          valid;
        logic          hs;
        logic          vs;
        logic          blank;
        logic          eol;
        logic          evl;
        logic          eof;
        logic          nlv;
        logic          running;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [FW-1:0] fc;
    } obs_t;

    typedef struct {
        logic          en;
        logic          valid;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          blank;
        logic          running;
    } vec_t;

    obs_t dut_o;
    obs_t m;
    bit   m_stop;
    int   edge_n;

    video_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .FRAME_CNT_W(FW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en),
        .hsync_o(hsync), .vsync_o(vsync), .blank_n_o(blank_n),
        .x_o(x), .y_o(y), .valid_o(valid),
        .end_of_line_o(eol), .end_of_visible_line_o(evl), .end_of_frame_o(eof),
        .next_line_visible_o(nlv), .frame_cnt_o(fc), .running_o(running)
    );

    always #5 clk = ~clk;

    assign dut_o = {valid, hsync, vsync, blank_n, eol, evl, eof, nlv, running, x, y, fc};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m       = '0;
        m.hs    = !HPOL;
        m.vs    = !VPOL;
        m.nlv   = 1'b1;
        m_stop  = 1'b0;
        edge_n  = 0;
    endtask

    task automatic model_step_pos();
        if (int'(m.x) == HT - 1) begin
            m.x = '0;
            if (int'(m.y) == VT - 1) begin
                m.y  = '0;
                m.fc = m.fc + 1'b1;
            end else begin
                m.y = m.y + 1'b1;
            end
        end else begin
            m.x = m.x + 1'b1;
        end
    endtask

    // One clock edge of the reference: pixel beats land on clocks 2, 2+CLK_DIV, ...
    task automatic model_edge(input bit e);
        bit present;
        int xi, yi;
        edge_n++;
        m.valid = 0; m.eol = 0; m.evl = 0; m.eof = 0;
        if (edge_n < 2 || ((edge_n - 2) % CLK_DIV) != 0) return;
        present = 0;
        if (!m.running) begin
            if (e) begin
                m.running = 1; m_stop = 0; m.x = '0; m.y = '0; present = 1;
            end
        end else if (e) begin
            m_stop = 0; model_step_pos(); present = 1;
        end else if (m_stop && int'(m.x) == HT - 1 && int'(m.y) == VT - 1) begin
            m.running = 0; m.hs = !HPOL; m.vs = !VPOL; m.blank = 0;
        end else begin
            m_stop = 1; model_step_pos(); present = 1;
        end
        if (present) begin
            xi      = int'(m.x);
            yi      = int'(m.y);
            m.valid = 1;
            m.hs    = (xi >= HV + HF && xi < HV + HF + HS) ? HPOL : !HPOL;
            m.vs    = (yi >= VV + VF && yi < VV + VF + VS) ? VPOL : !VPOL;
            m.blank = (xi < HV) && (yi < VV);
            m.eol   = (xi == HV);
            m.evl   = (xi == HV) && (yi < VV);
            m.eof   = (xi == HV) && (yi == VV - 1);
            m.nlv   = ((yi + 1) % VT) < VV;
        end
    endtask

    // Advance one clock, update the model, and compare at the falling edge.
    task automatic cycle(input string name);
        @(posedge clk);
        if (rst_n) model_edge(en);
        @(negedge clk);
        check(name, 64'(dut_o), 64'(m));
    endtask

    task automatic wait_beat(input int wx, input int wy, input int budget, input string name);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            cycle(name);
            if (valid && int'(x) == wx && int'(y) == wy) hit = 1;
        end
        if (!hit) check({name, "_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic async_reset(input string name);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check(name, 64'(dut_o), 64'(m));
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        vec_t tbl[6];
        int   hs_bad, vs_bad, nlv_bad, evl_cnt, eof_cnt;
        int   eof_x, eof_y, fc_seen_n, gap, maxgap, vcnt;
        logic [FW-1:0] fc_seen[3];
        logic [FW-1:0] fc_save;

        // Clock-by-clock start-up after reset release, enable held high.
        tbl[0] = '{1'b1, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 4'd0, 3'd0, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 4'd0, 3'd0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 4'd1, 3'd0, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 4'd1, 3'd0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 4'd2, 3'd0, 1'b1, 1'b1};

        // Reset values.
        rst_n = 1'b0;
        en    = 1'b1;
        model_reset();
        #12;
        check("reset_values",
              64'({valid, hsync, vsync, blank_n, eol, evl, eof, nlv, running, x, y, fc}),
              64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0, 16'd0}));
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;

        for (int i = 0; i < 6; i++) begin
            en = tbl[i].en;
            cycle("startup_model");
            check($sformatf("startup_row%0d", i),
                  64'({valid, x, y, blank_n, running}),
                  64'({tbl[i].valid, tbl[i].x, tbl[i].y, tbl[i].blank, tbl[i].running}));
        end

        // Rest of the first frame: sync and pulse decode against fixed expectations.
        hs_bad = 0; vs_bad = 0; nlv_bad = 0; evl_cnt = 0; eof_cnt = 0; eof_x = -1; eof_y = -1;
        for (int i = 0; i < 2 * HT * VT - 6; i++) begin
            cycle("frame1_model");
            if (valid) begin
                if (hsync !== !(x == 4'd10 || x == 4'd11)) hs_bad++;
                if (vsync !== !(y == 3'd5)) vs_bad++;
                if (nlv !== (y == 3'd7 || y <= 3'd2)) nlv_bad++;
                if (evl) evl_cnt++;
                if (eof) begin eof_cnt++; eof_x = int'(x); eof_y = int'(y); end
            end
        end
        check("hsync_only_x10_11", 64'(hs_bad), 64'(0));
        check("vsync_only_y5", 64'(vs_bad), 64'(0));
        check("next_line_visible", 64'(nlv_bad), 64'(0));
        check("end_of_visible_line_count", 64'(evl_cnt), 64'(4));
        check("end_of_frame_count", 64'(eof_cnt), 64'(1));
        check("end_of_frame_pos", 64'({eof_x, eof_y}), 64'({32'd8, 32'd3}));
        check("frame1_last_beat", 64'({x, y}), 64'({4'd13, 3'd7}));

        // Three more frames: frame counter at each (0,0) beat.
        fc_seen_n = 0;
        for (int i = 0; i < 3 * 2 * HT * VT; i++) begin
            cycle("frames_model");
            if (valid && x == '0 && y == '0 && fc_seen_n < 3) begin
                fc_seen[fc_seen_n] = fc;
                fc_seen_n++;
            end
        end
        check("frame_wrap_count", 64'(fc_seen_n), 64'(3));
        for (int i = 0; i < 3; i++)
            check($sformatf("frame_cnt_%0d", i + 1), 64'(fc_seen[i]), 64'(i + 1));

        // Stop request mid-frame: frame finishes, then idle, then restart at (0,0).
        wait_beat(3, 2, 2 * HT * VT + 4, "stop_wait_3_2");
        en = 1'b0;
        wait_beat(13, 7, 2 * HT * VT + 4, "stop_wait_13_7");
        check("stop_running_last_beat", 64'(running), 64'(1));
        cycle("stop_model");
        cycle("stop_model");
        check("stop_running_idle", 64'(running), 64'(0));
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle("idle_model");
            if (valid) vcnt++;
        end
        check("idle_no_valid", 64'(vcnt), 64'(0));
        fc_save = fc;
        en = 1'b1;
        wait_beat(0, 0, 4, "restart_wait");
        check("restart_frame_cnt_held", 64'(fc), 64'(fc_save));

        // Drop and re-raise within one frame: no gap, normal frame increment.
        wait_beat(5, 1, 2 * HT * VT + 4, "blip_wait_5_1");
        fc_save = fc;
        en = 1'b0;
        for (int i = 0; i < 6; i++) cycle("blip_model");
        en = 1'b1;
        gap = 0; maxgap = 0; vcnt = 0;
        for (int i = 0; i < 2 * HT * VT + 4 && vcnt == 0; i++) begin
            cycle("blip_model");
            gap++;
            if (valid) begin
                if (gap > maxgap) maxgap = gap;
                gap = 0;
                if (x == '0 && y == '0) vcnt = 1;
            end
        end
        check("blip_reached_origin", 64'(vcnt), 64'(1));
        check("blip_no_gap", 64'(maxgap), 64'(2));
        check("blip_frame_cnt", 64'(fc), 64'(fc_save + 1'b1));

        // Asynchronous reset mid-frame, then restart from (0,0).
        wait_beat(5, 6, 2 * HT * VT + 4, "rst_wait_5_6");
        async_reset("async_reset_mid_frame");
        cycle("after_reset_model");
        cycle("after_reset_model");
        check("after_reset_first_beat", 64'({valid, x, y, fc}), 64'({1'b1, 4'd0, 3'd0, 16'd0}));

        // Randomised enable traffic and occasional resets against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) en = !en;
            if ($urandom_range(0, 1499) == 0) async_reset("random_async_reset");
            cycle("random_model");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
